hazard_controller: RTL and testbench

Pipeline hazard scheduler for the RV32IMF five-stage core. It computes the 2-bit select codes that drive the execute-stage operand hazard muxes, and detects load-use hazards. It sequences multi-cycle M-extension operations (div/rem) with an internal counter FSM. It generates the stall and flush controls for the F/D/E/M pipeline registers, including branch flushes driven by the branch-select result.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/forward_unit.sv | 22 ++
 rtl/hazard_controller.sv | 132 +++++++++++++
 tb/tb_hazard_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding select codes and FSM states.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef enum logic {
    RUN,
    MC_BUSY
  } mc_state_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding select for one execute-stage source operand.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  output logic [1:0]       fwd_sel
);

  // Memory stage is checked last so that it wins over writeback.
  always_comb begin
    fwd_sel = FWD_RF;
    if (regwrite_w && (rd_w != '0) && (rd_w == rs)) fwd_sel = FWD_WB;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) fwd_sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard scheduler: operand forwarding, load-use stall, branch flush
// and multi-cycle (div/rem) execute sequencing.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 32,
  parameter int REG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             mc_start_e,
  input  logic             branch_taken,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             mc_busy,
  output logic             mc_done
);

  localparam int CNT_W = $clog2(MC_LAT);

  mc_state_t        state_q, state_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             mc_stall, mc_last, load_use;

  forward_unit #(.REG_W(REG_W)) u_fwd_a (
    .rs         (rs1_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd_sel    (fwd_a_raw)
  );

  forward_unit #(.REG_W(REG_W)) u_fwd_b (
    .rs         (rs2_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd_sel    (fwd_b_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    mc_stall = 1'b0;
    mc_last  = 1'b0;
    case (state_q)
      RUN: begin
        if (mc_start_e) begin
          mc_stall = 1'b1;
          mc_cnt_d = CNT_W'(MC_LAT - 2);
          state_d  = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (mc_cnt_q != '0) begin
          mc_stall = 1'b1;
          mc_cnt_d = mc_cnt_q - CNT_W'(1);
        end else begin
          mc_last = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign load_use = memtoreg_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Outputs are gated with rst_n so every output reads 0 while reset is held,
  // including the purely combinational forwarding and hazard paths.
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    if (rst_n) begin
      fwd_a_e = fwd_a_raw;
      fwd_b_e = fwd_b_raw;
      mc_busy = (state_q == MC_BUSY);
      mc_done = mc_last;
      if (mc_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (branch_taken) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: vector table, multi-cycle sequences and a
// randomized run against a cycle-count reference model.
module tb_hazard_controller;

  localparam int LAT1 = 32;
  localparam int LAT2 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_m, regwrite_w, memtoreg_e, mc_start_e, mc_start2, branch_taken;

  logic [1:0] fa1, fb1, fa2, fb2;
  logic       sf1, sd1, se1, fd1, fe1, fm1, bz1, dn1;
  logic       sf2, sd2, se2, fd2, fe2, fm2, bz2, dn2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MC_LAT(LAT1), .REG_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .mc_start_e(mc_start_e), .branch_taken(branch_taken),
    .fwd_a_e(fa1), .fwd_b_e(fb1), .stall_f(sf1), .stall_d(sd1), .stall_e(se1),
    .flush_d(fd1), .flush_e(fe1), .flush_m(fm1), .mc_busy(bz1), .mc_done(dn1)
  );

  hazard_controller #(.MC_LAT(LAT2), .REG_W(5)) u2 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .mc_start_e(mc_start2), .branch_taken(branch_taken),
    .fwd_a_e(fa2), .fwd_b_e(fb2), .stall_f(sf2), .stall_d(sd2), .stall_e(se2),
    .flush_d(fd2), .flush_e(fe2), .flush_m(fm2), .mc_busy(bz2), .mc_done(dn2)
  );

  // {fwd_a, fwd_b, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy, mc_done}
  logic [11:0] got1, got2;
  assign got1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1, bz1, dn1};
  assign got2 = {fa2, fb2, sf2, sd2, se2, fd2, fe2, fm2, bz2, dn2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0; mc_start_e = 0; mc_start2 = 0;
    branch_taken = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs1_e, rs2_e, rd_m, rd_w;
    logic       rwm, rww;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       mtr, br;
    logic [1:0] ea, eb;
    logic       esf, esd, efd, efe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] r1e, r2e, rdm, rdw, input logic rwm, rww,
                     input logic [4:0] r1d, r2d, rde, input logic mtr, br,
                     input logic [1:0] ea, eb, input logic esf, esd, efd, efe);
    vec_t v;
    v.rs1_e = r1e; v.rs2_e = r2e; v.rd_m = rdm; v.rd_w = rdw; v.rwm = rwm; v.rww = rww;
    v.rs1_d = r1d; v.rs2_d = r2d; v.rd_e = rde; v.mtr = mtr; v.br = br;
    v.ea = ea; v.eb = eb; v.esf = esf; v.esd = esd; v.efd = efd; v.efe = efe;
    vecs.push_back(v);
  endtask

  // Reference model: forwarding rule and position within a multi-cycle op.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, rdm, rdw, input logic rwm, rww);
    if (rwm && rdm != 0 && rdm == rs) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  int phase = -1;  // cycles since the current op's start cycle, -1 when idle

  function automatic logic [11:0] ref_out(input int p, input int lat);
    logic lu, st, busy, done, sf, sd, se, fd, fe, fm;
    lu   = memtoreg_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    st   = (p >= 0) && (p < lat - 1);
    busy = (p >= 1);
    done = (p == lat - 1);
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0;
    if (st) begin
      sf = 1; sd = 1; se = 1; fm = 1;
    end else begin
      fd = branch_taken;
      fe = branch_taken || lu;
      sf = lu && !branch_taken;
      sd = sf;
    end
    return {ref_fwd(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w),
            ref_fwd(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w),
            sf, sd, se, fd, fe, fm, busy, done};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] e;
    int p;

    // Reset with active forwarding and hazard inputs: everything must read 0.
    idle_inputs();
    rst_n = 1'b0;
    rs1_e = 5; rd_m = 5; regwrite_m = 1; memtoreg_e = 1; rd_e = 3; rs1_d = 3; mc_start_e = 1;
    #1;
    chk("reset_outputs_u1", {20'd0, got1}, 32'd0);
    chk("reset_outputs_u2", {20'd0, got2}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Table-driven combinational checks in RUN.
    add(5, 0, 5, 5, 1, 1,  0, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0, 0);
    add(5, 0, 5, 5, 0, 1,  0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0);
    add(3, 9, 3, 9, 1, 1,  0, 0, 0, 0, 0,  2'b10, 2'b01, 0, 0, 0, 0);
    add(4, 4, 6, 4, 1, 0,  0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 7, 7, 1, 0,  2'b00, 2'b00, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  1, 7, 7, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  7, 2, 7, 1, 1,  2'b00, 2'b00, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  2, 3, 4, 0, 1,  2'b00, 2'b00, 0, 0, 1, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      regwrite_m = vecs[i].rwm; regwrite_w = vecs[i].rww; rs1_d = vecs[i].rs1_d;
      rs2_d = vecs[i].rs2_d; rd_e = vecs[i].rd_e; memtoreg_e = vecs[i].mtr;
      branch_taken = vecs[i].br;
      #1;
      chk($sformatf("vec%0d", i), {20'd0, got1},
          {20'd0, vecs[i].ea, vecs[i].eb, vecs[i].esf, vecs[i].esd, 1'b0,
           vecs[i].efd, vecs[i].efe, 1'b0, 1'b0, 1'b0});
    end

    // MC_LAT=32 op with a branch pulse in the middle.
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c <= 33; c++) begin
      if (c > 0) @(negedge clk);
      mc_start_e   = (c == 0);
      branch_taken = (c == 10);
      #1;
      chk($sformatf("mc32_stall_c%0d", c), {29'd0, se1, sf1, fm1},
          (c < LAT1 - 1) ? 32'd7 : 32'd0);
      chk($sformatf("mc32_busy_done_c%0d", c), {30'd0, bz1, dn1},
          {30'd0, (c >= 1 && c <= LAT1 - 1), (c == LAT1 - 1)});
      if (c == 10) chk("mc32_branch_ignored", {30'd0, fd1, fe1}, 32'd0);
    end

    // MC_LAT=2 back-to-back ops.
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) @(negedge clk);
      mc_start2 = (c == 0 || c == 2);
      #1;
      chk($sformatf("mc2_c%0d", c), {29'd0, se2, bz2, dn2},
          {29'd0, (c == 0 || c == 2), (c == 1 || c == 3), (c == 1 || c == 3)});
    end

    // Reset in cycle 10 of a MC_LAT=32 op aborts it with no done pulse.
    @(negedge clk);
    idle_inputs();
    mc_start_e = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mc_start_e = 0;
    end
    rs1_e = 6; rd_w = 6; regwrite_w = 1;
    #1;
    chk("abort_pre_busy", {31'd0, bz1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", {20'd0, got1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    begin
      int saw = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        #1;
        if (dn1 || bz1 || se1) saw++;
      end
      chk("abort_no_done", saw, 0);
    end

    // Randomized run against the reference model.
    do_reset();
    phase = -1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      regwrite_m   = 1'($urandom_range(0, 1));
      regwrite_w   = 1'($urandom_range(0, 1));
      memtoreg_e   = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 3) == 0);
      mc_start_e   = ($urandom_range(0, 19) == 0);
      p = (phase < 0 && mc_start_e) ? 0 : phase;
      #1;
      e = ref_out(p, LAT1);
      chk($sformatf("rand_c%0d", c), {20'd0, got1}, {20'd0, e});
      phase = (p < 0 || p == LAT1 - 1) ? -1 : p + 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
